phase_differentiator: RTL

- Inverse of the frequency-to-phase accumulator: converts a stream of wrapped phase-error samples back into a frequency-error word.
- Computes the modular difference between the current phase sample and the sample taken DECIM valid samples earlier.
- Sits after a phase detector, or on the accumulator output for loop-back checking, and feeds frequency-domain servo logic.

---
 rtl/phase_differentiator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/phase_differentiator.sv
// ----------------------------------------------------------------------------
// phase_differentiator
//
// Turns a stream of wrapped phase samples back into a frequency-error word.
// Each output is the difference between the sample that closes a window and
// the sample that closed the previous window (or primed the block). The
// subtraction is taken modulo 2^INPUT_WIDTH, so a step across the +/-pi
// boundary is not seen as a jump.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   PERROR     signed phase sample, taken when in_valid=1
//   in_valid   qualifies PERROR for one cycle
//   decim      valid samples per output word (0 acts as 1)
//   FERROR     signed frequency error, registered and held between updates
//   out_valid  one-cycle pulse when FERROR updates
//   primed     high once a reference sample is held
//   sat_flag   (PHASE_DIFF_SAT_EN only) the current FERROR was clipped
//
// Build option:
//   PHASE_DIFF_SAT_EN  saturate instead of truncate when OUTPUT_WIDTH is
//                      narrower than INPUT_WIDTH, and add sat_flag.
//
// State | meaning
// ------+-----------------------------------------------------------------
// PRIME | no reference yet; the first valid sample becomes the reference
// RUN   | reference held; counting valid samples toward the window close
// ----------------------------------------------------------------------------
module phase_differentiator #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DECIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  PERROR,
  input  logic                    in_valid,
  input  logic [DECIM_WIDTH-1:0]  decim,
  output logic [OUTPUT_WIDTH-1:0] FERROR,
  output logic                    out_valid,
`ifdef PHASE_DIFF_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    primed
);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [INPUT_WIDTH-1:0]  r_ref;
  logic [DECIM_WIDTH-1:0]  r_cnt;
  logic [DECIM_WIDTH-1:0]  r_decim;
  logic [OUTPUT_WIDTH-1:0] r_ferror;
  logic                    r_out_valid;

  logic [DECIM_WIDTH-1:0]  w_decim_eff;
  logic                    w_close;
  logic [INPUT_WIDTH-1:0]  w_diff;
  logic [OUTPUT_WIDTH-1:0] w_ferror;
  logic                    w_clipped;

  assign w_decim_eff = (decim == '0) ? DECIM_WIDTH'(1) : decim;
  // Unsigned subtraction wraps mod 2^INPUT_WIDTH; the result is read as signed.
  assign w_diff      = PERROR - r_ref;

  always_comb begin
    w_state_next = r_state;
    w_close      = 1'b0;
    case (r_state)
      PRIME: if (in_valid) w_state_next = RUN;
      RUN:   w_close = in_valid && (r_cnt == (r_decim - DECIM_WIDTH'(1)));
      default: w_state_next = PRIME;
    endcase
  end

`ifdef PHASE_DIFF_SAT_EN
  localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  // The value fits only if every bit from the output sign bit upward agrees.
  always_comb begin
    w_ferror  = w_diff[OUTPUT_WIDTH-1:0];
    w_clipped = 1'b0;
    if (OUTPUT_WIDTH < INPUT_WIDTH) begin
      if (!((&w_diff[INPUT_WIDTH-1:OUTPUT_WIDTH-1]) ||
            (~|w_diff[INPUT_WIDTH-1:OUTPUT_WIDTH-1]))) begin
        w_clipped = 1'b1;
        w_ferror  = w_diff[INPUT_WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end
  end

  logic r_sat_flag;
  assign sat_flag = r_sat_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_flag <= 1'b0;
    end else if (w_close) begin
      r_sat_flag <= w_clipped;
    end
  end
`else
  always_comb begin
    w_ferror  = w_diff[OUTPUT_WIDTH-1:0];
    w_clipped = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PRIME;
      r_ref       <= '0;
      r_cnt       <= '0;
      r_decim     <= DECIM_WIDTH'(1);
      r_ferror    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_close;
      if (r_state == PRIME) begin
        if (in_valid) begin
          r_ref   <= PERROR;
          r_cnt   <= '0;
          r_decim <= w_decim_eff;
        end
      end else if (w_close) begin
        r_ref    <= PERROR;
        r_cnt    <= '0;
        r_decim  <= w_decim_eff;
        r_ferror <= w_ferror;
      end else if (in_valid) begin
        r_cnt <= r_cnt + DECIM_WIDTH'(1);
      end
    end
  end

  assign FERROR    = r_ferror;
  assign out_valid = r_out_valid;
  assign primed    = (r_state == RUN);

endmodule
